// File: rtl/draw_pkg.sv
// Shared types and constants for the board drawing stage: FSM states,
// board geometry, colours and the number-drawer glyph length.
package draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILL,
    NUM_RST,
    DRAW,
    NEXT,
    DONE
  } draw_state_e;

  localparam int DEF_BOARD_X0   = 20;
  localparam int DEF_BOARD_Y0   = 0;
  localparam int DEF_TILE_SIZE  = 30;
  localparam int DEF_NUM_CYCLES = 141;

  localparam logic [2:0] DEF_TILE_COLOUR  = 3'b111;
  localparam logic [2:0] DEF_BLANK_COLOUR = 3'b000;
  localparam logic [2:0] DEF_NUM_COLOUR   = 3'b001;

  // Cell k of the packed board lives at bits [4k+3:4k].
  function automatic logic [3:0] cell_value(input logic [63:0] board,
                                            input logic [3:0]  idx);
    return board[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/rect_raster.sv
// Two-level x/y raster counter over a width x height rectangle, x innermost.
// last flags the final pixel so the caller can leave its fill state.
module rect_raster (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [4:0] width,
  input  logic [4:0] height,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic       last
);

  logic [4:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic       x_end, y_end;

  always_comb begin
    x_end = (x_q == width - 5'd1);
    y_end = (y_q == height - 5'd1);
    x_d   = x_q;
    y_d   = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (enable) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? 5'd0 : y_q + 5'd1;
      end else begin
        x_d = x_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end & y_end;

endmodule

// File: rtl/board_draw_sequencer.sv
// Walks the 4x4 board in row-major order: fills each tile background, then
// hands the cell to the number-drawer bank and forwards its pixel stream.
module board_draw_sequencer
  import draw_pkg::*;
#(
  parameter int         BOARD_X0     = DEF_BOARD_X0,
  parameter int         BOARD_Y0     = DEF_BOARD_Y0,
  parameter int         TILE_SIZE    = DEF_TILE_SIZE,
  parameter int         NUM_CYCLES   = DEF_NUM_CYCLES,
  parameter logic [2:0] TILE_COLOUR  = DEF_TILE_COLOUR,
  parameter logic [2:0] BLANK_COLOUR = DEF_BLANK_COLOUR,
  parameter logic [2:0] NUM_COLOUR   = DEF_NUM_COLOUR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] board,
  output logic        busy,
  output logic        done,
  output logic [3:0]  num_sel,
  output logic        num_reset,
  output logic        num_enable,
  output logic [7:0]  tile_x,
  output logic [6:0]  tile_y,
  input  logic [7:0]  num_x,
  input  logic [6:0]  num_y,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  draw_state_e state_q, state_d;
  logic [63:0] board_q, board_d;
  logic [3:0]  cell_q, cell_d;
  logic [7:0]  draw_cnt_q, draw_cnt_d;
  logic [7:0]  tile_x_q, tile_x_d;
  logic [6:0]  tile_y_q, tile_y_d;
  logic [7:0]  vga_x_q;
  logic [6:0]  vga_y_q;
  logic [2:0]  vga_colour_q;

  logic [3:0]  cur_val;
  logic        raster_en, raster_clr, raster_last;
  logic [4:0]  fx, fy;

  function automatic logic [7:0] origin_x(input logic [3:0] c);
    return 8'(BOARD_X0) + 8'(TILE_SIZE) * {6'd0, c[1:0]};
  endfunction

  function automatic logic [6:0] origin_y(input logic [3:0] c);
    return 7'(BOARD_Y0) + 7'(TILE_SIZE) * {5'd0, c[3:2]};
  endfunction

  rect_raster u_fill (
    .clk    (clk),
    .reset  (reset),
    .clear  (raster_clr),
    .enable (raster_en),
    .width  (5'(TILE_SIZE)),
    .height (5'(TILE_SIZE)),
    .x      (fx),
    .y      (fy),
    .last   (raster_last)
  );

  assign cur_val = cell_value(board_q, cell_q);
  assign num_sel = cur_val;
  assign tile_x  = tile_x_q;
  assign tile_y  = tile_y_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    cell_d     = cell_q;
    draw_cnt_d = '0;
    tile_x_d   = tile_x_q;
    tile_y_d   = tile_y_q;
    busy       = 1'b1;
    done       = 1'b0;
    num_reset  = 1'b0;
    num_enable = 1'b0;
    raster_en  = 1'b0;
    raster_clr = 1'b1;
    vga_plot   = 1'b0;
    vga_x      = vga_x_q;
    vga_y      = vga_y_q;
    vga_colour = vga_colour_q;

    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        num_reset = 1'b1;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        board_d  = board;
        cell_d   = '0;
        tile_x_d = origin_x(4'd0);
        tile_y_d = origin_y(4'd0);
        state_d  = FILL;
      end
      FILL: begin
        raster_en  = 1'b1;
        raster_clr = 1'b0;
        vga_plot   = 1'b1;
        vga_x      = tile_x_q + {3'd0, fx};
        vga_y      = tile_y_q + {2'd0, fy};
        vga_colour = (cur_val == 4'd0) ? BLANK_COLOUR : TILE_COLOUR;
        if (raster_last) state_d = (cur_val != 4'd0) ? NUM_RST : NEXT;
      end
      NUM_RST: begin
        num_reset = 1'b1;
        state_d   = DRAW;
      end
      DRAW: begin
        num_enable = 1'b1;
        vga_plot   = 1'b1;
        vga_x      = num_x;
        vga_y      = num_y;
        vga_colour = NUM_COLOUR;
        if (draw_cnt_q == 8'(NUM_CYCLES - 1)) begin
          state_d = NEXT;
        end else begin
          draw_cnt_d = draw_cnt_q + 8'd1;
        end
      end
      NEXT: begin
        if (cell_q == 4'd15) begin
          state_d = DONE;
        end else begin
          cell_d   = cell_q + 4'd1;
          tile_x_d = origin_x(cell_q + 4'd1);
          tile_y_d = origin_y(cell_q + 4'd1);
          state_d  = FILL;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      // NOTE: the latched board is reset too, so num_sel reads 0 out of reset.
      board_q      <= '0;
      cell_q       <= '0;
      draw_cnt_q   <= '0;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      cell_q       <= cell_d;
      draw_cnt_q   <= draw_cnt_d;
      tile_x_q     <= tile_x_d;
      tile_y_q     <= tile_y_d;
      vga_x_q      <= vga_x;
      vga_y_q      <= vga_y;
      vga_colour_q <= vga_colour;
    end
  end

endmodule

// File: tb/tb_board_draw_sequencer.sv
// Directed bench for board_draw_sequencer with a simple number-drawer model
// and a negedge monitor that tallies plots, colours and drawer handshakes.
module tb_board_draw_sequencer;
  import draw_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] board = '0;
  logic        busy, done, num_reset, num_enable, vga_plot;
  logic [3:0]  num_sel;
  logic [7:0]  tile_x, vga_x, num_x;
  logic [6:0]  tile_y, vga_y, num_y;
  logic [2:0]  vga_colour;

  int n_tests = 0;
  int n_fail  = 0;

  board_draw_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .board      (board),
    .busy       (busy),
    .done       (done),
    .num_sel    (num_sel),
    .num_reset  (num_reset),
    .num_enable (num_enable),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .num_x      (num_x),
    .num_y      (num_y),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  // Number-drawer model: counter 0..140, glyph pixels offset from the cell origin.
  int drw_cnt = 0;
  always @(posedge clk) begin
    if (num_reset) drw_cnt <= 0;
    else if (num_enable) drw_cnt <= (drw_cnt == 140) ? 0 : drw_cnt + 1;
  end
  assign num_x = tile_x + 8'(drw_cnt % 12);
  assign num_y = tile_y + 7'(drw_cnt / 12);

  // Monitor tallies
  int busy_cnt = 0, done_cnt = 0, nr_cnt = 0, plot_cnt = 0, draw_cnt = 0;
  int tile_cnt = 0, blank_cnt = 0, fill_bad = 0, draw_bad = 0;
  int runs = 0, run_bad = 0, rst_bad = 0, run_len = 0;
  logic prev_busy = 1'b0, prev_en = 1'b0, prev_nr = 1'b0;
  logic armed = 1'b0, c15_seen = 1'b0;
  logic [7:0] first_x = '0, c15_x = '0;
  logic [6:0] first_y = '0, c15_y = '0;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (busy && num_reset) nr_cnt++;
    if (busy && !prev_busy) begin
      armed    = 1'b1;
      c15_seen = 1'b0;
    end
    if (vga_plot) begin
      plot_cnt++;
      if (armed) begin
        first_x = vga_x;
        first_y = vga_y;
        armed   = 1'b0;
      end
      if (!c15_seen && tile_x == 8'd110 && tile_y == 7'd90) begin
        c15_x    = vga_x;
        c15_y    = vga_y;
        c15_seen = 1'b1;
      end
      if (num_enable) begin
        draw_cnt++;
        if (vga_colour !== 3'b001 || vga_x !== num_x || vga_y !== num_y) draw_bad++;
      end else if (vga_colour === 3'b111) tile_cnt++;
      else if (vga_colour === 3'b000) blank_cnt++;
      else fill_bad++;
    end else if (num_enable) begin
      draw_bad++;
    end
    if (num_enable) begin
      if (!prev_en) begin
        runs++;
        if (!prev_nr) rst_bad++;
        run_len = 1;
      end else begin
        run_len++;
      end
    end else if (prev_en && run_len != 141) begin
      run_bad++;
    end
    prev_busy = busy;
    prev_en   = num_enable;
    prev_nr   = num_reset;
  end

  int b_busy, b_done, b_nr, b_plot, b_draw, b_tile, b_blank;
  int b_fill_bad, b_draw_bad, b_runs, b_run_bad, b_rst_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    b_busy = busy_cnt;   b_done = done_cnt;   b_nr = nr_cnt;
    b_plot = plot_cnt;   b_draw = draw_cnt;   b_tile = tile_cnt;
    b_blank = blank_cnt; b_fill_bad = fill_bad; b_draw_bad = draw_bad;
    b_runs = runs;       b_run_bad = run_bad; b_rst_bad = rst_bad;
  endtask

  task automatic start_frame(input logic [63:0] b);
    @(negedge clk);
    #1;
    snapshot();
    board = b;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (done !== 1'b1 && i < 20000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int e_busy, input int e_plot,
                             input int e_draw, input int e_tile, input int e_blank,
                             input int e_nz);
    check({tag, "_busy_cycles"}, 32'(busy_cnt - b_busy), 32'(e_busy));
    check({tag, "_plots"},       32'(plot_cnt - b_plot), 32'(e_plot));
    check({tag, "_num_plots"},   32'(draw_cnt - b_draw), 32'(e_draw));
    check({tag, "_tile_plots"},  32'(tile_cnt - b_tile), 32'(e_tile));
    check({tag, "_blank_plots"}, 32'(blank_cnt - b_blank), 32'(e_blank));
    check({tag, "_num_reset_cycles"}, 32'(nr_cnt - b_nr), 32'(e_nz));
    check({tag, "_enable_runs"}, 32'(runs - b_runs), 32'(e_nz));
    check({tag, "_run_len_bad"}, 32'(run_bad - b_run_bad), 32'd0);
    check({tag, "_no_reset_before_run"}, 32'(rst_bad - b_rst_bad), 32'd0);
    check({tag, "_fill_colour_bad"}, 32'(fill_bad - b_fill_bad), 32'd0);
    check({tag, "_draw_pixel_bad"},  32'(draw_bad - b_draw_bad), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_cnt - b_done), 32'd1);
  endtask

  logic [63:0] board2, board3;
  int          k;

  initial begin
    for (k = 0; k < 15; k++) board2[4*k +: 4] = 4'(k + 1);
    board2[63:60] = 4'd0;
    board3 = 64'h0000_0000_0000_0001;

    // Reset held 3 cycles, then idle with no start.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tile_x", 32'(tile_x), 32'd0);
    check("rst_tile_y", 32'(tile_y), 32'd0);
    check("rst_vga_x", 32'(vga_x), 32'd0);
    check("rst_num_sel", 32'(num_sel), 32'd0);
    check("rst_num_enable", 32'(num_enable), 32'd0);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_plot", 32'(vga_plot), 32'd0);
      check("idle_num_reset", 32'(num_reset), 32'd1);
    end

    // All-zero board.
    start_frame('0);
    wait_done("zero");
    check_frame("zero", 14418, 14400, 0, 0, 14400, 0);
    check("zero_first_x", 32'(first_x), 32'd20);
    check("zero_first_y", 32'(first_y), 32'd0);

    // Cells 1..15 numbered, cell 15 blank.
    start_frame(board2);
    wait_done("seq");
    check_frame("seq", 16548, 16515, 2115, 13500, 900, 15);
    check("seq_first_x", 32'(first_x), 32'd20);
    check("seq_first_y", 32'(first_y), 32'd0);
    check("seq_cell15_seen", 32'(c15_seen), 32'd1);
    check("seq_cell15_x", 32'(c15_x), 32'd110);
    check("seq_cell15_y", 32'(c15_y), 32'd90);

    // Second start and board change during FILL of cell 3.
    start_frame(board3);
    begin
      int i;
      i = 0;
      while (!(vga_plot && !num_enable && tile_x == 8'd110 && tile_y == 7'd0) && i < 20000) begin
        @(negedge clk);
        i++;
      end
      check("mid_cell3_reached", 32'(tile_x), 32'd110);
    end
    #1;
    start = 1'b1;
    board = {16{4'hF}};
    @(negedge clk);
    #1 start = 1'b0;
    wait_done("latch");
    check_frame("latch", 14560, 14541, 141, 900, 13500, 1);
    repeat (5) @(negedge clk);
    check("latch_no_requeue_busy", 32'(busy), 32'd0);
    check("latch_single_done", 32'(done_cnt - b_done), 32'd1);

    // Reset during DRAW of cell 5, then a fresh frame.
    start_frame(board2);
    begin
      int i;
      i = 0;
      while (!(num_enable && tile_x == 8'd50 && tile_y == 7'd30) && i < 20000) begin
        @(negedge clk);
        i++;
      end
      check("abort_cell5_draw", 32'(num_enable), 32'd1);
    end
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_plot", 32'(vga_plot), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_num_enable", 32'(num_enable), 32'd0);
    #1 reset = 1'b0;
    start_frame(board2);
    wait_done("redo");
    check_frame("redo", 16548, 16515, 2115, 13500, 900, 15);
    check("redo_first_x", 32'(first_x), 32'd20);
    check("redo_first_y", 32'(first_y), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
